// File: rtl/cr_structs.sv
// rtl/cr_structs.sv - shared stream bus struct and egress framing FSM state type
package cr_structs;

    // Data-path stream beat; tuser[0] marks start of transfer (SoT)
    typedef struct packed {
        logic        tvalid;
        logic        tlast;
        logic [7:0]  tid;
        logic [7:0]  tuser;
        logic [7:0]  tstrb;
        logic [63:0] tdata;
    } axi4s_dp_bus_t;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } tlvp_ob_axis_fsm_e;

    function automatic logic is_sot(input axi4s_dp_bus_t beat);
        return beat.tuser[0];
    endfunction

endpackage

// File: rtl/cr_tlvp_ob_skid.sv
// rtl/cr_tlvp_ob_skid.sv - 2-entry in-order skid buffer, head entry is the output register
module cr_tlvp_ob_skid
    import cr_structs::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  axi4s_dp_bus_t push_data,
    input  logic          pop,
    output logic [1:0]    cnt,
    output axi4s_dp_bus_t head
);

    axi4s_dp_bus_t ent0;
    axi4s_dp_bus_t ent1;
    logic [1:0]    cnt_q;

    // Occupancy and entry shifting; ent0 is always the oldest beat.
    // The caller never pushes when full nor pops when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0 <= push_data;
                    else               ent1 <= push_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        ent0 <= push_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cnt  = cnt_q;
    assign head = ent0;

endmodule

// File: rtl/cr_tlvp_ob_axis.sv
// rtl/cr_tlvp_ob_axis.sv - TLV parser egress: FIFO pop to AXI4-stream, framing check; stats under CR_TLVP_OB_AXIS_STATS_EN
module cr_tlvp_ob_axis
    import cr_structs::*;
#(
    parameter int STAT_WIDTH = 32,
    parameter int CHECK_EN   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tlvp_ob_empty,
    input  logic                  tlvp_ob_aempty,
    input  axi4s_dp_bus_t         tlvp_ob,
    output logic                  tlvp_ob_rd,
    output axi4s_dp_bus_t         m_axis,
    input  logic                  m_axis_tready,
    output logic                  framing_err,
    output logic [STAT_WIDTH-1:0] frame_cnt,
    output logic [STAT_WIDTH-1:0] beat_cnt
);

    logic              unused_aempty;
    logic [1:0]        cnt;
    axi4s_dp_bus_t     head;
    logic              out_hs;
    tlvp_ob_axis_fsm_e state_q;
    tlvp_ob_axis_fsm_e state_nxt;
    logic              violation;

    assign unused_aempty = tlvp_ob_aempty;

    // Pop depends only on buffer occupancy, never on downstream ready
    assign tlvp_ob_rd = !tlvp_ob_empty && (cnt != 2'd2);
    assign out_hs     = (cnt != 2'd0) && m_axis_tready;

    cr_tlvp_ob_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (tlvp_ob_rd),
        .push_data (tlvp_ob),
        .pop       (out_hs),
        .cnt       (cnt),
        .head      (head)
    );

    // Output beat is the buffer head; valid whenever anything is buffered
    always_comb begin
        m_axis        = head;
        m_axis.tvalid = (cnt != 2'd0);
    end

    // Framing decode of the popped beat; any beat ends in the state it implies
    always_comb begin
        violation = 1'b0;
        state_nxt = state_q;
        if (tlvp_ob_rd) begin
            if (state_q == IDLE) violation = !is_sot(tlvp_ob);
            else                 violation = is_sot(tlvp_ob);
            state_nxt = tlvp_ob.tlast ? IDLE : IN_FRAME;
        end
    end

    // FSM state and registered one-cycle error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            framing_err <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            framing_err <= (CHECK_EN != 0) && violation;
        end
    end

`ifdef CR_TLVP_OB_AXIS_STATS_EN
    logic [STAT_WIDTH-1:0] frame_q;
    logic [STAT_WIDTH-1:0] beat_q;

    // Saturating counters of output handshakes and completed frames
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            beat_q  <= '0;
        end else if (out_hs) begin
            if (beat_q != '1) beat_q <= beat_q + STAT_WIDTH'(1);
            if (m_axis.tlast && (frame_q != '1)) frame_q <= frame_q + STAT_WIDTH'(1);
        end
    end

    assign frame_cnt = frame_q;
    assign beat_cnt  = beat_q;
`else
    assign frame_cnt = '0;
    assign beat_cnt  = '0;
`endif

endmodule

// File: tb/tb_cr_tlvp_ob_axis.sv
// tb/tb_cr_tlvp_ob_axis.sv - randomized scoreboard bench for cr_tlvp_ob_axis
module tb_cr_tlvp_ob_axis;
    import cr_structs::*;

    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tlvp_ob_empty = 1'b1;
    logic          tlvp_ob_aempty = 1'b1;
    axi4s_dp_bus_t tlvp_ob = '0;
    logic          tlvp_ob_rd;
    axi4s_dp_bus_t m_axis;
    logic          m_axis_tready = 1'b0;
    logic          framing_err;
    logic [SW-1:0] frame_cnt;
    logic [SW-1:0] beat_cnt;

    always #5 clk = ~clk;

    cr_tlvp_ob_axis #(.STAT_WIDTH(SW), .CHECK_EN(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .tlvp_ob_empty  (tlvp_ob_empty),
        .tlvp_ob_aempty (tlvp_ob_aempty),
        .tlvp_ob        (tlvp_ob),
        .tlvp_ob_rd     (tlvp_ob_rd),
        .m_axis         (m_axis),
        .m_axis_tready  (m_axis_tready),
        .framing_err    (framing_err),
        .frame_cnt      (frame_cnt),
        .beat_cnt       (beat_cnt)
    );

    int            n_chk = 0;
    int            n_fail = 0;
    axi4s_dp_bus_t src_q[$];
    axi4s_dp_bus_t exp_q[$];
    int            tready_mode = 0;
    bit            rst_req = 1'b1;
    bit            rst_chk = 1'b0;
    bit            rd_prev = 1'b0;
    bit            in_frame = 1'b0;
    int            mdl_beats = 0;
    int            mdl_frames = 0;
    bit            prev_stall = 1'b0;
    axi4s_dp_bus_t prev_out = '0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_cnt(input int v);
`ifdef CR_TLVP_OB_AXIS_STATS_EN
        return (v > (1 << SW) - 1) ? (1 << SW) - 1 : v;
`else
        return 0;
`endif
    endfunction

    // Reference framing rules applied to a beat taken from the source
    function automatic bit frame_model(input axi4s_dp_bus_t b);
        bit sot = b.tuser[0];
        bit err = 1'b0;
        if (!in_frame) begin
            if (!sot) err = 1'b1;
            in_frame = !b.tlast;
        end else begin
            if (sot) begin
                err = 1'b1;
                in_frame = !b.tlast;
            end else if (b.tlast) begin
                in_frame = 1'b0;
            end
        end
        return err;
    endfunction

    // Source FIFO model, reset sequencing and framing_err checking
    initial begin
        axi4s_dp_bus_t b;
        bit err_now;
        forever begin
            @(negedge clk);
            if (rst_chk) begin
                chk("rst_m_axis", 96'(m_axis), 96'(0));
                chk("rst_rd", 96'(tlvp_ob_rd), 96'(0));
                chk("rst_frame_cnt", 96'(frame_cnt), 96'(0));
                chk("rst_beat_cnt", 96'(beat_cnt), 96'(0));
                rst_chk = 1'b0;
            end
            err_now = 1'b0;
            if (rd_prev && src_q.size() > 0) begin
                b = src_q.pop_front();
                err_now = frame_model(b);
            end
            chk("framing_err", 96'(framing_err), 96'(err_now));
            if (rst_req) begin
                rst = 1'b1;
                rst_req = 1'b0;
                src_q.delete();
                exp_q.delete();
                in_frame = 1'b0;
                mdl_beats = 0;
                mdl_frames = 0;
                rst_chk = 1'b1;
            end else begin
                rst = 1'b0;
            end
            tlvp_ob_empty = (src_q.size() == 0);
            tlvp_ob = (src_q.size() == 0) ? '0 : src_q[0];
            case (tready_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            rd_prev = tlvp_ob_rd;
        end
    end

    // Output monitor: scoreboard compare, hold-under-stall and counter checks
    initial begin
        axi4s_dp_bus_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                chk("frame_cnt", 96'(frame_cnt), 96'(exp_cnt(mdl_frames)));
                chk("beat_cnt", 96'(beat_cnt), 96'(exp_cnt(mdl_beats)));
                if (prev_stall) chk("hold_m_axis", 96'(m_axis), 96'(prev_out));
                if (m_axis.tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 96'(m_axis), 96'(0));
                    end else begin
                        e = exp_q.pop_front();
                        e.tvalid = 1'b1;
                        chk("beat", 96'(m_axis), 96'(e));
                        mdl_beats++;
                        if (e.tlast) mdl_frames++;
                    end
                end
                prev_stall = m_axis.tvalid && !m_axis_tready;
                prev_out = m_axis;
            end
        end
    end

    task automatic add_beat(input bit sot, input bit last);
        axi4s_dp_bus_t b;
        b.tvalid = 1'b1;
        b.tlast  = last;
        b.tid    = 8'($urandom);
        b.tuser  = {7'($urandom), sot};
        b.tstrb  = 8'($urandom);
        b.tdata  = {$urandom, $urandom};
        src_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #3;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && k < budget) begin
            cycles(1);
            k++;
        end
        n_chk++;
        if (exp_q.size() != 0 || src_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
        end
        cycles(3);
    endtask

    initial begin
        cycles(3);

        // Continuous 4-beat frame, always ready
        tready_mode = 1;
        for (int i = 0; i < 4; i++) add_beat(i == 0, i == 3);
        drain(50);
        chk("A_beat_cnt", 96'(beat_cnt), 96'(exp_cnt(4)));
        chk("A_frame_cnt", 96'(frame_cnt), 96'(exp_cnt(1)));

        // Backpressure with a full source
        tready_mode = 0;
        for (int i = 0; i < 8; i++) add_beat(i % 4 == 0, i % 4 == 3);
        cycles(5);
        chk("B_rd_low", 96'(tlvp_ob_rd), 96'(0));
        chk("B_tvalid", 96'(m_axis.tvalid), 96'(1));
        tready_mode = 1;
        drain(50);

        // Single-beat frames
        for (int i = 0; i < 3; i++) add_beat(1'b1, 1'b1);
        drain(50);

        // Framing violations: non-SoT in IDLE, then SoT mid-frame
        add_beat(1'b0, 1'b0);
        add_beat(1'b0, 1'b1);
        add_beat(1'b1, 1'b0);
        add_beat(1'b1, 1'b0);
        add_beat(1'b0, 1'b1);
        drain(50);

        // Random flags with random backpressure
        tready_mode = 2;
        for (int i = 0; i < 60; i++) add_beat($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        drain(1000);
        add_beat(1'b0, 1'b1);
        drain(50);

        // Reset with a full buffer, then a clean frame
        tready_mode = 0;
        for (int i = 0; i < 6; i++) add_beat(i == 0, 1'b0);
        cycles(4);
        rst_req = 1'b1;
        cycles(3);
        tready_mode = 1;
        for (int i = 0; i < 3; i++) add_beat(i == 0, i == 2);
        drain(50);

        // Counter saturation
        for (int i = 0; i < 20; i++) add_beat(i % 4 == 0, i % 4 == 3);
        drain(100);
        chk("G_beat_sat", 96'(beat_cnt), 96'(exp_cnt(23)));
        chk("G_frame_cnt", 96'(frame_cnt), 96'(exp_cnt(6)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cr_tlvp_ob_axis.md
# cr_tlvp_ob_axis

Egress adapter downstream of the TLV parser's output FIFO. It pops beats from the `tlvp_ob` show-ahead FIFO interface (empty/rd) and presents them as a registered AXI4-stream master with valid/ready backpressure. It runs a frame-framing checker on the beats it forwards and, optionally, keeps frame and beat statistics. It sits between the TLV parser wrapper and the next engine's ingress.

## Interface
Parameters:
- `STAT_WIDTH`, 32: width of the frame and beat counters.
- `CHECK_EN`, 1: 1 enables the framing checker; 0 ties `framing_err` to 0.

Ports:
- `clk`  in  1  core clock; every register is clocked on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `tlvp_ob_empty`  in  1  source FIFO empty.
- `tlvp_ob_aempty`  in  1  source FIFO almost empty; unused, kept for interface symmetry.
- `tlvp_ob`  in  axi4s_dp_bus_t  head beat of the source FIFO; valid while `tlvp_ob_empty`=0.
- `tlvp_ob_rd`  out  1  pop strobe to the source FIFO.
- `m_axis`  out  axi4s_dp_bus_t  output beat; `m_axis.tvalid` is the stream valid.
- `m_axis_tready`  in  1  downstream ready.
- `framing_err`  out  1  one-cycle pulse when a framing violation is detected.
- `frame_cnt`  out  STAT_WIDTH  count of completed frames.
- `beat_cnt`  out  STAT_WIDTH  count of forwarded beats.

## Operation
- Buffer: 2-entry skid FIFO with occupancy `cnt` in 0..2. The head entry drives `m_axis`; `m_axis.tvalid` = (`cnt`≠0).
- Pop rule: `tlvp_ob_rd` = !`tlvp_ob_empty` && (`cnt`<2).
  - Driven only from registered state and `tlvp_ob_empty`.
  - No combinational path from `m_axis_tready` to `tlvp_ob_rd`.
- Push: the beat is captured on the cycle `tlvp_ob_rd`=1.
- Pop: the head entry is removed on the cycle `m_axis.tvalid` && `m_axis_tready`.
- Push and pop in the same cycle leave `cnt` unchanged, and entry order is preserved.
- `m_axis` contents are held stable while tvalid=1 and tready=0 (AXI rule).
- Framing FSM, evaluated on each beat that is popped from the source:
  - `IDLE`: a beat with `tuser[0]` (SoT) goes to `IN_FRAME`. If that same beat also has `tlast`, the FSM stays in `IDLE` (single-beat frame).
  - `IN_FRAME`: a beat with `tlast` goes back to `IDLE`.
- Framing violations (both require CHECK_EN=1):
  - a non-SoT beat received in `IDLE`;
  - an SoT beat received in `IN_FRAME`.
- On a violation: `framing_err` pulses on the next cycle. The beat is still forwarded unmodified. The FSM moves to the state the beat implies: SoT → `IN_FRAME`, or `tlast` → `IDLE`.

## Timing
- Latency: a beat popped in cycle N is visible on `m_axis` in cycle N+1.
- Throughput: sustained 1 beat/cycle while tready=1 and the source is non-empty (steady state `cnt`=1).
- With `cnt`=2, no pop occurs that cycle even if tready=1. The cycle is recovered because the buffer keeps driving the output.
- Reset values:
  - `cnt`=0, so `m_axis.tvalid`=0; all other `m_axis` fields are 0.
  - `tlvp_ob_rd`=0, `framing_err`=0, FSM in `IDLE`, counters 0.
- Reset mid-frame: buffered beats are discarded; there is no drain. Upstream is reset by the same `rst`.
- `framing_err` is registered, and asserts exactly one cycle after the offending pop.

## Configuration
- Macro: `CR_TLVP_OB_AXIS_STATS_EN`.
- Defined:
  - `beat_cnt` increments on each output handshake.
  - `frame_cnt` increments on each output handshake with `tlast`=1.
  - Both counters saturate at all-ones and do not wrap; both are registered.
- Undefined: both counters and their increment logic are removed. `frame_cnt` and `beat_cnt` are tied to 0.

## Structure
- Shared package `cr_structs`: `axi4s_dp_bus_t` (existing), plus a new `tlvp_ob_axis_fsm_e` enum {`IDLE`, `IN_FRAME`}.
- Sub-module `cr_tlvp_ob_skid` holds the 2-entry buffer (push, pop, `cnt`, head output). The top level contains the pop rule, the framing FSM and the statistics.

## Test plan
- Stream, always ready: source holds 4 beats (SoT on beat 0, tlast on beat 3) and tready=1 → `tlvp_ob_rd` high for 4 consecutive cycles; beats appear in cycles 1–4 in order; `frame_cnt`=1, `beat_cnt`=4; no `framing_err`.
- Backpressure: tready=0 for 5 cycles with a full source → `cnt` reaches 2, `tlvp_ob_rd` drops, `m_axis` is stable. Releasing tready delivers every beat exactly once with none lost.
- Single-beat frame: SoT and tlast on one beat, repeated 3 times → `frame_cnt`=3, FSM stays in `IDLE`, no error.
- Framing errors:
  - a beat without SoT in `IDLE` → `framing_err` pulses one cycle after the pop, and the beat is still output;
  - an SoT received mid-frame → error pulse, and the FSM stays in `IN_FRAME`.
- Reset mid-frame: `rst` asserted with `cnt`=2 → next cycle tvalid=0, `cnt`=0, counters 0. A new SoT frame after reset produces no error.
- Saturation (macro defined, STAT_WIDTH=4): 20 beats → `beat_cnt` holds at 15.
- Macro undefined: the same stimuli give `frame_cnt`=`beat_cnt`=0 throughout.
